// File: rtl/hidden_layer_accumulator_if.sv
// Upstream queue handshake and weight-memory bus seen by hidden_layer_accumulator.
// The slave modport is the accumulator side; the master modport is the queue/memory side.
`timescale 1ns/1ps
interface hidden_layer_accumulator_if #(
    parameter int WEIGHT_W = 8,
    parameter int WADDR_W  = 14
);
    logic                       queue_finished;
    logic                       queue_empty;
    logic [9:0]                 index_in;
    logic                       dequeue;
    logic [WADDR_W-1:0]         w_addr;
    logic                       w_rd;
    logic signed [WEIGHT_W-1:0] w_data;

    modport slave (
        input  queue_finished, queue_empty, index_in, w_data,
        output dequeue, w_addr, w_rd
    );

    modport master (
        output queue_finished, queue_empty, index_in, w_data,
        input  dequeue, w_addr, w_rd
    );
endinterface

// File: rtl/hidden_layer_accumulator.sv
// Drains active-pixel indexes from the input queue and sums one signed weight per hidden node.
// Define HIDDEN_ACC_SATURATE_EN for saturating sums with a sticky overflow flag (default: wrap).
`timescale 1ns/1ps
module hidden_layer_accumulator #(
    parameter int INPUT_NODES  = 784,
    parameter int HIDDEN_NODES = 16,
    parameter int WEIGHT_W     = 8,
    parameter int ACC_W        = 16,
    parameter int WADDR_W      = 14,
    parameter int SEL_W        = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    hidden_layer_accumulator_if.slave bus,
    input  logic [SEL_W-1:0]        acc_sel,
    output logic signed [ACC_W-1:0] acc_out,
    output logic [9:0]              active_count,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow
);

    if (((1 << SEL_W) < HIDDEN_NODES) || (INPUT_NODES > 1024)) begin : g_param_chk
        $error("hidden_layer_accumulator: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        IDLE, WAIT_FILL, CHECK, DEQ, LATCH, RD, ACC, DONE
    } state_t;

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q [HIDDEN_NODES];
    logic [9:0]              idx_q;
    logic [9:0]              cnt_q;
    logic [SEL_W-1:0]        j_q;
    logic                    start_ok;
    logic                    last_j;
    logic signed [ACC_W-1:0] sum_d;

    assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));
    assign last_j   = (j_q == SEL_W'(HIDDEN_NODES - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = WAIT_FILL;
            WAIT_FILL:  if (bus.queue_finished) state_d = CHECK;
            CHECK:      state_d = bus.queue_empty ? DONE : DEQ;
            DEQ:        state_d = LATCH;
            LATCH:      state_d = RD;
            RD:         state_d = ACC;
            ACC:        state_d = last_j ? CHECK : RD;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                cnt_q <= '0;
            end else if (state_q == LATCH) begin
                idx_q <= bus.index_in;
                cnt_q <= cnt_q + 10'd1;
                j_q   <= '0;
            end else if ((state_q == ACC) && !last_j) begin
                j_q <= j_q + SEL_W'(1);
            end
        end
    end

`ifdef HIDDEN_ACC_SATURATE_EN
    localparam logic signed [ACC_W:0] ACC_MAX = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] ACC_MIN = {2'b11, {(ACC_W-1){1'b0}}};

    // Returns {clamped, sum}; the extra bit keeps the true sum before clamping.
    function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] a,
                                               input logic signed [WEIGHT_W-1:0] w);
        logic signed [ACC_W:0] s;
        s = (ACC_W+1)'(a) + (ACC_W+1)'(w);
        if (s > ACC_MAX) return {1'b1, ACC_MAX[ACC_W-1:0]};
        if (s < ACC_MIN) return {1'b1, ACC_MIN[ACC_W-1:0]};
        return {1'b0, s[ACC_W-1:0]};
    endfunction

    logic clamp_d;
    logic ovf_q;

    always_comb {clamp_d, sum_d} = sat_add(acc_q[j_q], bus.w_data);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                             ovf_q <= 1'b0;
        else if (start_ok)                     ovf_q <= 1'b0;
        else if ((state_q == ACC) && clamp_d)  ovf_q <= 1'b1;
    end

    assign overflow = ovf_q;
`else
    function automatic logic signed [ACC_W-1:0] wrap_add(input logic signed [ACC_W-1:0] a,
                                                         input logic signed [WEIGHT_W-1:0] w);
        return a + ACC_W'(w);
    endfunction

    assign sum_d    = wrap_add(acc_q[j_q], bus.w_data);
    assign overflow = 1'b0;
`endif

    // w_data belongs to the RD issued one cycle earlier, so the add happens in ACC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < HIDDEN_NODES; i++) acc_q[i] <= '0;
        end else if (start_ok) begin
            for (int i = 0; i < HIDDEN_NODES; i++) acc_q[i] <= '0;
        end else if (state_q == ACC) begin
            acc_q[j_q] <= sum_d;
        end
    end

    assign bus.dequeue = (state_q == DEQ);
    assign bus.w_rd    = (state_q == RD);
    assign bus.w_addr  = WADDR_W'(32'(idx_q) * 32'(HIDDEN_NODES) + 32'(j_q));

    always_comb begin
        acc_out = '0;
        if (int'(acc_sel) < HIDDEN_NODES) acc_out = acc_q[acc_sel];
    end

    assign active_count = cnt_q;
    assign busy         = (state_q != IDLE) && (state_q != DONE);
    assign done         = (state_q == DONE);

endmodule

// File: tb/tb_hidden_layer_accumulator.sv
// Scoreboard bench for hidden_layer_accumulator: stimulus queues expected results,
// a monitor pops them on each done rising edge or snapshot request.
`timescale 1ns/1ps
module tb_hidden_layer_accumulator;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [3:0]         acc_sel;
    logic signed [15:0] acc_out;
    logic [9:0]         active_count;
    logic               busy, done, overflow;

    always #5 clk = ~clk;

    hidden_layer_accumulator_if #(.WEIGHT_W(8), .WADDR_W(14)) bus ();

    hidden_layer_accumulator dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bus          (bus),
        .acc_sel      (acc_sel),
        .acc_out      (acc_out),
        .active_count (active_count),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow)
    );

    typedef struct packed {
        int t_ref;
        int lat;
        int cnt;
        int dn;
        int bsy;
        int ovf;
        int deq;
        int ndeq;
        int nrd;
        int base;
        logic [15:0][15:0] acc;
    } exp_t;

    // Hand-computed sums for w = (addr mod 7) - 3.
    int T_BASIC [16] = '{-1, 2, -2, 1, -3, 0, 3, -1, 2, -2, 1, -3, 0, 3, -1, 2};  // {0,5,783}
    int T_ADDR  [16] = '{1, 2, 3, -3, -2, -1, 0, 1, 2, 3, -3, -2, -1, 0, 1, 2};   // {100}
    int T_ONE   [16] = '{-1, 0, 1, 2, 3, -3, -2, -1, 0, 1, 2, 3, -3, -2, -1, 0};  // {1}

    int   n_chk = 0, n_pass = 0;
    int   cyc = 0;
    exp_t sb[$];
    int   snap_req = 0, snap_ack = 0, handled = 0;

    int         qv [300];
    int         qlen = 0;
    int         ptr = 0, ndeq = 0, nrd = 0, rdc = 0;
    bit         prev_rd = 1'b0;
    logic [13:0] last_addr = '0;
    int         addr_log[$];
    bit         q_clr = 1'b1;
    bit         qf = 1'b0;
    bit         wmode = 1'b0;

    assign bus.queue_empty    = (ptr >= qlen);
    assign bus.queue_finished = qf;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic signed [7:0] wgt(input logic [13:0] a);
        return 8'(int'(a % 14'd7) - 3);
    endfunction

    // Queue and synchronous weight memory model; weight appears only in the cycle after w_rd.
    always @(negedge clk) begin
        if (q_clr) begin
            ptr     <= 0;
            ndeq    <= 0;
            nrd     <= 0;
            rdc     <= 0;
            prev_rd <= 1'b0;
            addr_log.delete();
        end else begin
            if (prev_rd) bus.w_data <= wmode ? 8'sd127 : wgt(last_addr);
            if (bus.dequeue && ptr < 300) begin
                bus.index_in <= 10'(qv[ptr]);
                ptr          <= ptr + 1;
                ndeq         <= ndeq + 1;
            end
            if (bus.w_rd) begin
                nrd       <= nrd + 1;
                last_addr <= bus.w_addr;
                addr_log.push_back(int'(bus.w_addr));
                if (prev_rd) rdc <= rdc + 1;
            end
            prev_rd <= bus.w_rd;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    function automatic exp_t mk(input int which);
        exp_t e;
        int   v;
        e.t_ref = 0; e.lat = -1; e.cnt = 0; e.dn = 0; e.bsy = 0; e.ovf = 0;
        e.deq = -1; e.ndeq = -1; e.nrd = -1; e.base = -1;
        for (int j = 0; j < 16; j++) begin
            case (which)
                1:       v = T_BASIC[j];
                2:       v = T_ADDR[j];
                3:       v = T_ONE[j];
`ifdef HIDDEN_ACC_SATURATE_EN
                4:       v = 32767;
`else
                4:       v = -27436;
`endif
                default: v = 0;
            endcase
            e.acc[j] = 16'(v);
        end
        return e;
    endfunction

    task automatic check_entry(input exp_t e);
        if (e.lat >= 0) chk("latency", cyc - e.t_ref, e.lat);
        chk("done", int'(done), e.dn);
        chk("busy", int'(busy), e.bsy);
        chk("active_count", int'(active_count), e.cnt);
        chk("overflow", int'(overflow), e.ovf);
        if (e.deq >= 0) begin
            chk("dequeue", int'(bus.dequeue), e.deq);
            chk("w_rd", int'(bus.w_rd), 0);
            chk("w_addr_rst", int'(bus.w_addr), 0);
        end
        if (e.ndeq >= 0) begin
            chk("dequeue_pulses", ndeq, e.ndeq);
            chk("w_rd_cycles", nrd, e.nrd);
            chk("w_rd_back_to_back", rdc, 0);
        end
        if (e.base >= 0) begin
            chk("w_addr_count", addr_log.size(), 16);
            for (int i = 0; i < 16; i++)
                chk($sformatf("w_addr[%0d]", i), (i < addr_log.size()) ? addr_log[i] : -1, e.base + i);
        end
        for (int j = 0; j < 16; j++) begin
            acc_sel = 4'(j);
            #1;
            chk($sformatf("acc[%0d]", j), int'(acc_out), int'($signed(e.acc[j])));
        end
    endtask

    initial begin : monitor
        bit   prev_done;
        bit   go;
        exp_t e;
        prev_done = 1'b0;
        acc_sel   = '0;
        forever begin
            @(negedge clk);
            go = (done && !prev_done) || (snap_req != snap_ack);
            prev_done = done;
            if (go) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", int'(done), 0);
                end else begin
                    e = sb.pop_front();
                    check_entry(e);
                    snap_ack = snap_req;
                    handled++;
                end
            end
        end
    end

    task automatic wait_handled(input int pre, input int budget);
        int k = 0;
        while (handled <= pre && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (handled <= pre) begin
            chk("timeout", handled, pre + 1);
            sb.delete();
        end
    endtask

    task automatic snap(input exp_t e);
        int pre;
        #1;
        pre = handled;
        sb.push_back(e);
        snap_req++;
        wait_handled(pre, 20);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic clear_model();
        q_clr = 1'b1;
        repeat (2) @(negedge clk);
        q_clr = 1'b0;
    endtask

    task automatic run_image(input exp_t e_in, input int budget);
        exp_t e;
        int   pre;
        e = e_in;
        e.t_ref = cyc + 1;
        pre = handled;
        sb.push_back(e);
        pulse_start();
        wait_handled(pre, budget);
    endtask

    initial begin : stim
        exp_t e;
        int   pre, k;
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state.
        e = mk(0); e.deq = 0;
        snap(e);
        reset = 1'b0;
        clear_model();

        // Basic image {0,5,783}.
        qv[0] = 0; qv[1] = 5; qv[2] = 783; qlen = 3; wmode = 1'b0; qf = 1'b1;
        clear_model();
        e = mk(1); e.lat = 107; e.cnt = 3; e.dn = 1; e.ndeq = 3; e.nrd = 48;
        run_image(e, 400);

        // Empty queue.
        qlen = 0;
        clear_model();
        e = mk(0); e.lat = 2; e.dn = 1; e.ndeq = 0; e.nrd = 0;
        run_image(e, 50);

        // Address sequence for index 100.
        qv[0] = 100; qlen = 1;
        clear_model();
        e = mk(2); e.lat = 37; e.cnt = 1; e.dn = 1; e.ndeq = 1; e.nrd = 16; e.base = 1600;
        run_image(e, 100);

        // Saturation / wrap with 300 indexes of +127 weights.
        for (int i = 0; i < 300; i++) qv[i] = i;
        qlen = 300; wmode = 1'b1;
        clear_model();
        e = mk(4); e.lat = 10502; e.cnt = 300; e.dn = 1; e.ndeq = 300; e.nrd = 4800;
`ifdef HIDDEN_ACC_SATURATE_EN
        e.ovf = 1;
`endif
        run_image(e, 11000);

        // Restart from DONE; start pulses while busy are ignored.
        qf = 1'b0; qv[0] = 1; qlen = 1; wmode = 1'b0;
        clear_model();
        pulse_start();
        repeat (2) @(negedge clk);
        e = mk(0); e.bsy = 1;
        snap(e);
        pulse_start();
        repeat (2) @(negedge clk);
        e = mk(3); e.lat = 36; e.cnt = 1; e.dn = 1; e.ndeq = 1; e.nrd = 16;
        e.t_ref = cyc + 1;
        pre = handled;
        sb.push_back(e);
        qf = 1'b1;
        repeat (10) @(negedge clk);
        pulse_start();
        wait_handled(pre, 100);

        // Reset asserted during ACC of the third index.
        qv[0] = 0; qv[1] = 5; qv[2] = 783; qlen = 3;
        clear_model();
        pulse_start();
        k = 0;
        while (!(active_count == 10'd3 && bus.w_rd) && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("reach_third_index_rd", int'(active_count), 3);
        @(negedge clk);
        reset = 1'b1;
        e = mk(0); e.deq = 0;
        snap(e);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hidden_layer_accumulator.md
Name: hidden_layer_accumulator

Overview:
- Consumer stage directly downstream of the input queue register.
- Once the queue reports all pixels read, drains the queue one active-pixel index at a time via its dequeue handshake.
- For each index, reads one signed weight per hidden node from an external synchronous weight memory and adds it into that node's accumulator.
- After the queue empties, presents the HIDDEN_NODES pre-activation sums to the activation stage through an indexed read port.

Parameters:
INPUT_NODES, 784, number of input pixels; legal index range 0..INPUT_NODES-1
HIDDEN_NODES, 16, number of hidden neurons, i.e. accumulators
WEIGHT_W, 8, signed weight width
ACC_W, 16, signed accumulator width
WADDR_W, 14, weight memory address width
SEL_W, 4, accumulator select width; must satisfy 2^SEL_W >= HIDDEN_NODES

Ports:
clk  in  1  clock; all logic on posedge
reset  in  1  asynchronous reset, active-high
start  in  1  one-cycle pulse; clears accumulators and begins a new image
queue_finished  in  1  upstream has read all pixels
queue_empty  in  1  upstream queue drained
index_in  in  10  index presented by upstream after a dequeue
dequeue  out  1  dequeue strobe to upstream
w_addr  out  WADDR_W  weight address = index*HIDDEN_NODES + j
w_rd  out  1  weight read enable
w_data  in  WEIGHT_W  signed weight; valid the cycle after w_rd
acc_sel  in  SEL_W  accumulator select for readout
acc_out  out  ACC_W  acc[acc_sel]; combinational; 0 if acc_sel >= HIDDEN_NODES
active_count  out  10  number of indexes processed this image
busy  out  1  high in every state except IDLE and DONE
done  out  1  high in DONE
overflow  out  1  sticky accumulator saturation flag (see Optional Feature)

Behaviour:
- Reset (asynchronous): state=IDLE; all accumulators=0; active_count=0; dequeue=0; w_rd=0; w_addr=0; done=0; overflow=0; index register=0; j=0. Reset mid-operation aborts immediately; no partial result is retained.
- States: IDLE, WAIT_FILL, CHECK, DEQ, LATCH, RD, ACC, DONE.
- IDLE: waits for start.
- start (accepted in IDLE or DONE only; ignored elsewhere):
  - next cycle all accumulators=0, active_count=0, overflow=0;
  - state -> WAIT_FILL.
- WAIT_FILL: stays until queue_finished=1, then -> CHECK.
- CHECK:
  - queue_empty=1 -> DONE;
  - otherwise -> DEQ.
- DEQ: dequeue=1 for exactly this one cycle -> LATCH.
- LATCH:
  - dequeue=0, which produces the upstream falling edge that advances its front pointer;
  - registers index_in; active_count++; j=0 -> RD.
- RD:
  - w_rd=1, w_addr = index*HIDDEN_NODES + j, truncated to WADDR_W;
  - -> ACC.
- ACC:
  - w_rd=0; acc[j] = acc[j] + sign-extended w_data;
  - j == HIDDEN_NODES-1 -> CHECK; else j++ and -> RD.
- Per-index cost: 3 + 2*HIDDEN_NODES cycles (DEQ, LATCH, RD/ACC pairs, CHECK) = 35 at defaults.
- queue_empty is sampled only in CHECK, at least 2*HIDDEN_NODES cycles after the dequeue falling edge, so it is settled.
- Index out of range (index_in >= INPUT_NODES): the index is still processed and the address computed; no error signalling. The bench must not generate it.
- DONE: done=1; accumulators and active_count hold until start or reset.
- Empty image (queue_empty already 1 at the first CHECK): DONE reached 2 cycles after queue_finished is seen; all acc=0; active_count=0.
- Only one accumulator is written per cycle; acc_out reflects writes on the cycle after they occur.

Optional Feature:
- Macro: HIDDEN_ACC_SATURATE_EN.
- Defined:
  - sums clamp to +(2^(ACC_W-1)-1) / -(2^(ACC_W-1));
  - overflow sets on any clamp and stays set until start or reset.
- Undefined:
  - two's-complement wrap;
  - overflow tied to 0.

Test Plan:
- Reset mid-ACC: assert reset during ACC of the 3rd index -> immediately state IDLE; acc_out=0 for all selects; dequeue=0; active_count=0.
- Basic image: start; queue holds indexes {0,5,783}; memory w_data = (addr mod 7) - 3 -> DONE after 3*35+WAIT_FILL cycles; active_count=3; acc[j] equals the software model sum for each j; exactly 3 dequeue pulses observed.
- Empty queue: start; queue_finished=1, queue_empty=1 -> done 2 cycles later; no dequeue pulses; no w_rd; all acc=0.
- Address check: single index 100 -> w_addr sequence 1600..1615, one per RD cycle, with w_rd high only in RD.
- Saturation: all weights +127; 300 active indexes -> with HIDDEN_ACC_SATURATE_EN, acc=32767 and overflow=1; without it, acc = 38100 mod 2^16 as signed = -27436 and overflow=0.
- Restart from DONE: pulse start in DONE, feed a new queue {1} -> accumulators cleared before accumulation; active_count=1; start pulses asserted while busy have no effect.
